// File: rtl/bcd_stopwatch_ctrl.sv
//------------------------------------------------------------------------------
// bcd_stopwatch_ctrl
//
// Four-digit BCD stopwatch controller. A prescaler divides clk into count
// ticks, a start/pause/clear state machine gates it, and four cascaded decade
// digits count 0000..9999 with 9->0 rollover. The digit register is the
// display register, so the display follows the count with no extra latency.
//
// Optional feature macro: STOPWATCH_LAP_EN
//   defined   : lap in RUN toggles a display hold (lap freeze), counting
//               continues underneath.
//   undefined : lap is accepted but ignored; no hold/capture state exists.
//
// Parameters
//   TICK_DIV   system clocks per count tick (1..65535)
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start_stop  in   one-cycle pulse, toggles run/pause
//   clear       in   one-cycle pulse, zeroes the count (wins over start_stop)
//   lap         in   one-cycle pulse, toggles display hold in RUN
//   display     out  BCD digits {d3,d2,d1,d0}
//   running     out  high while in RUN
//   wrap        out  one-cycle pulse after 9999 rolls to 0000
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module bcd_stopwatch_ctrl #(
   parameter int TICK_DIV = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_stop,
   input  logic        clear,
   input  logic        lap,
   output logic [15:0] display,
   output logic        running,
   output logic        wrap
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2
   } state_t;

   localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

   state_t      state, state_nxt;
   logic [15:0] presc, presc_nxt;
   logic [15:0] digits, digits_nxt;
   logic        wrap_nxt;
   logic        tick;

   // Ripple a +1 through four BCD digits. Bit 16 of the result is the carry
   // out of d3, i.e. the 9999 -> 0000 rollover.
   function automatic logic [16:0] bcd_inc(input logic [15:0] d);
      logic [15:0] r;
      logic        carry;
      r     = d;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (d[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = d[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return {carry, r};
   endfunction

   // Next-state / datapath control. Within a state, clear beats start_stop,
   // and start_stop beats a due tick, so a pause or clear edge never counts.
   always_comb begin
      state_nxt  = state;
      presc_nxt  = presc;
      digits_nxt = digits;
      wrap_nxt   = 1'b0;
      tick       = (state == S_RUN) && (presc == PRESC_MAX);

      case (state)
         S_IDLE: begin
            if (clear) begin
               digits_nxt = '0;
               presc_nxt  = '0;
            end else if (start_stop) begin
               state_nxt = S_RUN;
               presc_nxt = '0;
            end
         end
         S_RUN: begin
            if (clear) begin
               digits_nxt = '0;
               presc_nxt  = '0;
            end else if (start_stop) begin
               // prescaler keeps its phase so resume loses no partial tick
               state_nxt = S_PAUSE;
            end else if (tick) begin
               presc_nxt              = '0;
               {wrap_nxt, digits_nxt} = bcd_inc(digits);
            end else begin
               presc_nxt = presc + 16'd1;
            end
         end
         S_PAUSE: begin
            if (clear) begin
               state_nxt  = S_IDLE;
               digits_nxt = '0;
               presc_nxt  = '0;
            end else if (start_stop) begin
               state_nxt = S_RUN;
            end
         end
         default: begin
            state_nxt  = S_IDLE;
            digits_nxt = '0;
            presc_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         presc   <= '0;
         digits  <= '0;
         wrap    <= 1'b0;
         running <= 1'b0;
      end else begin
         state   <= state_nxt;
         presc   <= presc_nxt;
         digits  <= digits_nxt;
         wrap    <= wrap_nxt;
         running <= (state_nxt == S_RUN);
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic        hold, hold_nxt;
   logic [15:0] lap_q;

   // lap toggles hold only while running; anywhere else it releases it.
   always_comb begin
      hold_nxt = hold;
      if (clear) begin
         hold_nxt = 1'b0;
      end else if (lap) begin
         hold_nxt = (state == S_RUN) ? ~hold : 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold  <= 1'b0;
         lap_q <= '0;
      end else begin
         hold <= hold_nxt;
         // snapshot the digits as they stand when hold is being set
         if (lap && !clear && (state == S_RUN) && !hold) begin
            lap_q <= digits;
         end
      end
   end

   assign display = hold ? lap_q : digits;
`else
   logic lap_unused;
   assign lap_unused = lap;
   assign display    = digits;
`endif

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
`timescale 1ns/1ps
module tb_bcd_stopwatch_ctrl;

   localparam int DIV_A = 10;
   localparam int DIV_B = 1;
`ifdef STOPWATCH_LAP_EN
   localparam bit LAP_EN = 1'b1;
`else
   localparam bit LAP_EN = 1'b0;
`endif

   localparam logic [1:0] M_IDLE  = 2'd0;
   localparam logic [1:0] M_RUN   = 2'd1;
   localparam logic [1:0] M_PAUSE = 2'd2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_stop = 1'b0;
   logic        clear = 1'b0;
   logic        lap = 1'b0;
   logic [15:0] disp_a, disp_b;
   logic        run_a, run_b, wrap_a, wrap_b;

   always #5 clk = ~clk;

   bcd_stopwatch_ctrl #(.TICK_DIV(DIV_A)) dut_a (
      .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .clear(clear),
      .lap(lap), .display(disp_a), .running(run_a), .wrap(wrap_a)
   );

   bcd_stopwatch_ctrl #(.TICK_DIV(DIV_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .clear(clear),
      .lap(lap), .display(disp_b), .running(run_b), .wrap(wrap_b)
   );

   // Reference model: count kept as a plain integer 0..9999.
   typedef struct packed {
      logic [1:0]  st;
      logic [15:0] presc;
      logic [15:0] count;
      logic        hold;
      logic [15:0] held;
      logic        wrap;
   } mdl_t;

   mdl_t ma, mb;
   int   n_cmp = 0;
   int   n_bad = 0;

   typedef struct {
      bit          s;
      bit          c;
      bit          l;
      logic [15:0] disp;
      bit          run;
      bit          wrp;
   } vec_t;

   function automatic mdl_t mstep(input mdl_t m, input bit s, input bit c,
                                  input bit l, input int div);
      mdl_t n;
      bit   tick;
      n      = m;
      n.wrap = 1'b0;
      tick   = (m.st == M_RUN) && (int'(m.presc) == div - 1);
      if (c) begin
         n.count = '0;
         n.presc = '0;
         n.hold  = 1'b0;
         if (m.st != M_RUN) n.st = M_IDLE;
      end else if (s) begin
         if (m.st == M_IDLE) begin
            n.st    = M_RUN;
            n.presc = '0;
         end else if (m.st == M_RUN) begin
            n.st = M_PAUSE;
         end else begin
            n.st = M_RUN;
         end
      end else if (m.st == M_RUN) begin
         if (tick) begin
            n.presc = '0;
            if (int'(m.count) == 9999) n.wrap = 1'b1;
            n.count = 16'((int'(m.count) + 1) % 10000);
         end else begin
            n.presc = 16'(int'(m.presc) + 1);
         end
      end
      if (LAP_EN && !c && l) begin
         if (m.st == M_RUN) begin
            n.hold = !m.hold;
            if (!m.hold) n.held = m.count;
         end else begin
            n.hold = 1'b0;
         end
      end
      return n;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic [15:0] exp_disp(input mdl_t m);
      return to_bcd(m.hold ? int'(m.held) : int'(m.count));
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // One clock: drive pulses, advance both models at the edge, compare.
   task automatic step(input bit s, input bit c, input bit l);
      start_stop = s;
      clear      = c;
      lap        = l;
      @(posedge clk);
      ma = mstep(ma, s, c, l, DIV_A);
      mb = mstep(mb, s, c, l, DIV_B);
      #1;
      start_stop = 1'b0;
      clear      = 1'b0;
      lap        = 1'b0;
      check("model_a display", disp_a, exp_disp(ma));
      check("model_a running", run_a, (ma.st == M_RUN));
      check("model_a wrap", wrap_a, ma.wrap);
      check("model_b display", disp_b, exp_disp(mb));
      check("model_b running", run_b, (mb.st == M_RUN));
      check("model_b wrap", wrap_b, mb.wrap);
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      ma    = '0;
      mb    = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[17];
      ma = '0;
      mb = '0;

      // Table for the TICK_DIV=1 instance: every RUN cycle is a tick.
      tbl[0]  = '{1, 0, 0, 16'h0000, 1, 0};
      tbl[1]  = '{0, 0, 0, 16'h0001, 1, 0};
      tbl[2]  = '{0, 0, 0, 16'h0002, 1, 0};
      tbl[3]  = '{1, 0, 0, 16'h0002, 0, 0};
      tbl[4]  = '{0, 0, 0, 16'h0002, 0, 0};
      tbl[5]  = '{1, 0, 0, 16'h0002, 1, 0};
      tbl[6]  = '{0, 0, 0, 16'h0003, 1, 0};
      tbl[7]  = '{0, 1, 0, 16'h0000, 1, 0};
      tbl[8]  = '{0, 0, 0, 16'h0001, 1, 0};
      tbl[9]  = '{1, 1, 0, 16'h0000, 1, 0};
      tbl[10] = '{0, 0, 0, 16'h0001, 1, 0};
      tbl[11] = '{1, 0, 0, 16'h0001, 0, 0};
      tbl[12] = '{1, 1, 0, 16'h0000, 0, 0};
      tbl[13] = '{0, 1, 0, 16'h0000, 0, 0};
      tbl[14] = '{0, 0, 1, 16'h0000, 0, 0};
      tbl[15] = '{1, 0, 0, 16'h0000, 1, 0};
      tbl[16] = '{0, 0, 0, 16'h0001, 1, 0};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset display_a", disp_a, 16'h0000);
      check("reset running_a", run_a, 1'b0);
      check("reset wrap_a", wrap_a, 1'b0);
      check("reset display_b", disp_b, 16'h0000);
      check("reset running_b", run_b, 1'b0);
      check("reset wrap_b", wrap_b, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 17; i++) begin
         step(tbl[i].s, tbl[i].c, tbl[i].l);
         check($sformatf("tbl[%0d] display", i), disp_b, tbl[i].disp);
         check($sformatf("tbl[%0d] running", i), run_b, tbl[i].run);
         check($sformatf("tbl[%0d] wrap", i), wrap_b, tbl[i].wrp);
      end

      // Start latency with TICK_DIV=10
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      check("start running", run_a, 1'b1);
      for (int i = 1; i <= 9; i++) begin
         step(1'b0, 1'b0, 1'b0);
         check($sformatf("start wait %0d", i), disp_a, 16'h0000);
      end
      step(1'b0, 1'b0, 1'b0);
      check("first increment", disp_a, 16'h0001);
      idle_steps(10);
      check("second increment", disp_a, 16'h0002);

      // Carry ripple 0099 -> 0100
      idle_steps(970);
      check("reach 0099", disp_a, 16'h0099);
      idle_steps(10);
      check("ripple 0100", disp_a, 16'h0100);

      // Pause with prescaler at 6, resume, nothing lost
      idle_steps(6);
      step(1'b1, 1'b0, 1'b0);
      check("pause running", run_a, 1'b0);
      idle_steps(50);
      check("paused hold", disp_a, 16'h0100);
      step(1'b1, 1'b0, 1'b0);
      check("resume running", run_a, 1'b1);
      idle_steps(3);
      check("resume before tick", disp_a, 16'h0100);
      step(1'b0, 1'b0, 1'b0);
      check("resume tick", disp_a, 16'h0101);
      idle_steps(10);
      check("resume next tick", disp_a, 16'h0102);

      // start_stop + clear together in PAUSE, then in RUN
      step(1'b0, 1'b1, 1'b0);
      check("clear in run", disp_a, 16'h0000);
      idle_steps(420);
      check("reach 0042 a", disp_a, 16'h0042);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      check("both in pause display", disp_a, 16'h0000);
      check("both in pause running", run_a, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      check("idle stays stopped", run_a, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      idle_steps(420);
      check("reach 0042 b", disp_a, 16'h0042);
      step(1'b1, 1'b1, 1'b0);
      check("both in run display", disp_a, 16'h0000);
      check("both in run running", run_a, 1'b1);
      idle_steps(9);
      check("prescaler restart wait", disp_a, 16'h0000);
      step(1'b0, 1'b0, 1'b0);
      check("prescaler restart tick", disp_a, 16'h0001);

      // Lap hold
      step(1'b0, 1'b1, 1'b0);
      idle_steps(150);
      check("reach 0015", disp_a, 16'h0015);
      step(1'b0, 1'b0, 1'b1);
      check("lap capture", disp_a, 16'h0015);
      idle_steps(150);
      check("lap mid", disp_a, LAP_EN ? 16'h0015 : 16'h0030);
      idle_steps(150);
      check("lap end", disp_a, LAP_EN ? 16'h0015 : 16'h0045);
      step(1'b0, 1'b0, 1'b1);
      check("lap release", disp_a, 16'h0045);

      // Asynchronous reset mid-cycle at 0123
      step(1'b0, 1'b1, 1'b0);
      idle_steps(1230);
      check("reach 0123", disp_a, 16'h0123);
      #2;
      rst_n = 1'b0;
      ma    = '0;
      mb    = '0;
      #1;
      check("async reset display", disp_a, 16'h0000);
      check("async reset running", run_a, 1'b0);
      check("async reset wrap", wrap_a, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 1'b0, 1'b0);
      check("restart after reset", run_a, 1'b1);

      // 9999 -> 0000 rollover on the TICK_DIV=1 instance
      step(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 10100; i++) begin
         if (disp_b == 16'h9999) break;
         step(1'b0, 1'b0, 1'b0);
      end
      check("reach 9999", disp_b, 16'h9999);
      check("no early wrap", wrap_b, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      check("rollover display", disp_b, 16'h0000);
      check("rollover wrap", wrap_b, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      check("wrap one cycle", wrap_b, 1'b0);
      check("after rollover", disp_b, 16'h0001);

      // Random pulses against the model
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0,
              $urandom_range(0, 14) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
